instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader_pkg.sv | 15 +
 rtl/byte_packer.sv | 32 +++
 rtl/instruction_loader.sv | 96 +++++++++
 tb/tb_instruction_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the serial instruction loader.
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned MEM_DEPTH      = 40;
  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs serial bytes, MSB first, into one instruction word; flags the 4th byte.
module byte_packer
  import instruction_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift,
  input  logic [7:0]         byte_data,
  output logic [INSTR_W-1:0] word,
  output logic               word_full
);

  logic [INSTR_W-1:0] word_q;
  logic [1:0]         cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift) begin
      word_q <= {word_q[INSTR_W-9:0], byte_data};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  always_comb begin
    word      = word_q;
    word_full = shift && (cnt_q == 2'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads word_count instruction words from a byte stream into instruction memory,
// holding the CPU off while the load runs.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = instruction_loader_pkg::MEM_DEPTH,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [5:0]         word_count,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  state_t             state_q, state_d;
  logic [5:0]         count_q;
  logic [ADDR_W-1:0]  addr_q, addr_hold_q;
  logic [INSTR_W-1:0] wdata_hold_q;
  logic               error_q;

  logic               accept_start, start_ok, byte_accept, last_word;
  logic [INSTR_W-1:0] word;
  logic               word_full;

  byte_packer u_byte_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept_start && start_ok),
    .shift     (byte_accept),
    .byte_data (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    start_ok     = (word_count != '0) && (32'(word_count) <= MEM_DEPTH);
    accept_start = start && ((state_q == IDLE) || (state_q == DONE));
    byte_accept  = byte_valid && (state_q == LOAD);
    last_word    = (addr_q + ADDR_W'(1)) == ADDR_W'(count_q);

    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (accept_start) state_d = start_ok ? LOAD : DONE;
      LOAD:       if (word_full) state_d = WRITE;
      WRITE:      state_d = last_word ? DONE : LOAD;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      addr_q       <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        error_q <= !start_ok;
        if (start_ok) begin
          count_q <= word_count;
          addr_q  <= '0;
        end
      end
      // Address stops on the last word so it never reaches MEM_DEPTH.
      if (state_q == WRITE) begin
        addr_hold_q  <= addr_q;
        wdata_hold_q <= word;
        if (!last_word) addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  // Write port shows the live word during WRITE and the last written one otherwise.
  always_comb begin
    mem_we     = (state_q == WRITE);
    mem_addr   = mem_we ? addr_q : addr_hold_q;
    mem_wdata  = mem_we ? word : wdata_hold_q;
    byte_ready = (state_q == LOAD);
    cpu_hold   = (state_q == LOAD) || (state_q == WRITE);
    done       = (state_q == DONE);
    error      = error_q && (state_q == DONE);
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed scenarios plus random loads.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  word_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;

  int checks = 0;
  int passed = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  stim[$];
  logic [31:0] exp_data[$];

  instruction_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Write log: each strobe seen at the edge closing its cycle.
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  // Reference: word w is bytes 4w..4w+3 weighted MSB first, written to index w.
  function automatic void build_model();
    exp_data.delete();
    for (int w = 0; w < stim.size() / 4; w++) begin
      exp_data.push_back(32'(stim[4*w]) * 32'h0100_0000 + 32'(stim[4*w+1]) * 32'h0001_0000 +
                         32'(stim[4*w+2]) * 32'h0000_0100 + 32'(stim[4*w+3]));
    end
  endfunction

  function automatic int write_errors();
    int e = 0;
    if (wr_addr.size() != exp_data.size()) e++;
    for (int i = 0; i < wr_addr.size() && i < exp_data.size(); i++) begin
      if (wr_addr[i] !== 32'(i)) e++;
      if (wr_data[i] !== exp_data[i]) e++;
    end
    return e;
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic random_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
    build_model();
  endtask

  task automatic do_start(input logic [5:0] wc);
    start      = 1'b1;
    word_count = wc;
    @(negedge clk);
    start      = 1'b0;
    word_count = 6'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      $display("FAIL send_byte: byte_ready stuck at %b, required 1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic send_stim(input int max_gap);
    foreach (stim[i]) begin
      send_byte(stim[i]);
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (done !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (done !== 1'b1) $display("FAIL %s wait_done: done=%b, required 1", name, done);
    else passed++;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    start      = 1'b1;
    word_count = 6'd2;
    byte_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({byte_ready, mem_we, cpu_hold, done, error} !== 5'b0)
      $display("FAIL reset_flags: got %b, required 00000",
               {byte_ready, mem_we, cpu_hold, done, error});
    else passed++;
    checks++;
    if (mem_addr !== 32'h0) $display("FAIL reset_addr: got %h, required 0", mem_addr);
    else passed++;
    checks++;
    if (mem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h, required 0", mem_wdata);
    else passed++;
    rst        = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_after_reset: hold=%b done=%b, required 0 0", cpu_hold, done);
    else passed++;
  endtask

  task automatic test_two_words();
    clear_log();
    stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
    build_model();
    do_start(6'd2);
    checks++;
    if ({cpu_hold, byte_ready} !== 2'b11)
      $display("FAIL two_load_flags: hold/ready=%b, required 11", {cpu_hold, byte_ready});
    else passed++;
    for (int i = 0; i < 4; i++) send_byte(stim[i]);
    checks++;
    if ({mem_we, byte_ready} !== 2'b10 || mem_addr !== 32'd0 || mem_wdata !== 32'h2008_0005)
      $display("FAIL two_write0: we=%b ready=%b addr=%h data=%h, required 1 0 0 20080005",
               mem_we, byte_ready, mem_addr, mem_wdata);
    else passed++;
    for (int i = 4; i < 8; i++) send_byte(stim[i]);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'd1 || mem_wdata !== 32'h8C09_0000)
      $display("FAIL two_write1: we=%b addr=%h data=%h, required 1 1 8c090000",
               mem_we, mem_addr, mem_wdata);
    else passed++;
    @(negedge clk);
    checks++;
    if ({done, cpu_hold, mem_we} !== 3'b100)
      $display("FAIL two_done: done/hold/we=%b, required 100", {done, cpu_hold, mem_we});
    else passed++;
    checks++;
    if (mem_addr !== 32'd1 || mem_wdata !== 32'h8C09_0000)
      $display("FAIL two_hold_port: addr=%h data=%h, required 1 8c090000", mem_addr, mem_wdata);
    else passed++;
    checks++;
    if (write_errors() !== 0)
      $display("FAIL two_log: %0d writes with %0d errors, required 2 with 0",
               wr_addr.size(), write_errors());
    else passed++;
  endtask

  task automatic test_gaps();
    int gap_bad = 0;
    clear_log();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    build_model();
    do_start(6'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(stim[i]);
      if (i < 3) begin
        repeat (3) begin
          if (byte_ready !== 1'b1 || mem_we !== 1'b0) gap_bad++;
          @(negedge clk);
        end
      end
    end
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'd0 || mem_wdata !== 32'h0102_0304)
      $display("FAIL gaps_write: we=%b addr=%h data=%h, required 1 0 01020304",
               mem_we, mem_addr, mem_wdata);
    else passed++;
    wait_done("gaps");
    checks++;
    if (gap_bad !== 0) $display("FAIL gaps_idle: %0d bad gap cycles, required 0", gap_bad);
    else passed++;
    checks++;
    if (write_errors() !== 0)
      $display("FAIL gaps_log: %0d writes with %0d errors, required 1 with 0",
               wr_addr.size(), write_errors());
    else passed++;
  endtask

  task automatic test_full_depth();
    int high = 0;
    clear_log();
    stim.delete();
    for (int i = 0; i < 160; i++) stim.push_back(8'(i));
    build_model();
    do_start(6'd40);
    send_stim(0);
    wait_done("full");
    foreach (wr_addr[i]) if (wr_addr[i] >= 32'd40) high++;
    checks++;
    if (write_errors() !== 0 || high !== 0)
      $display("FAIL full_log: %0d writes, %0d errors, %0d addr>=40, required 40 0 0",
               wr_addr.size(), write_errors(), high);
    else passed++;
    checks++;
    if (wr_addr.size() == 0) $display("FAIL full_last: no writes, required addr 39");
    else if (wr_addr[$] !== 32'd39 || wr_data[$] !== 32'h9C9D_9E9F)
      $display("FAIL full_last: addr=%h data=%h, required 27 9c9d9e9f", wr_addr[$], wr_data[$]);
    else passed++;
  endtask

  task automatic test_illegal();
    logic [5:0] bad_counts[2] = '{6'd0, 6'd41};
    foreach (bad_counts[k]) begin
      clear_log();
      do_start(bad_counts[k]);
      checks++;
      if ({done, error, cpu_hold, byte_ready} !== 4'b1100)
        $display("FAIL illegal_%0d_flags: done/err/hold/ready=%b, required 1100",
                 bad_counts[k], {done, error, cpu_hold, byte_ready});
      else passed++;
      repeat (3) @(negedge clk);
      checks++;
      if (wr_addr.size() !== 0 || error !== 1'b1)
        $display("FAIL illegal_%0d_nowrite: %0d writes err=%b, required 0 1",
                 bad_counts[k], wr_addr.size(), error);
      else passed++;
    end
    clear_log();
    random_stim(4);
    do_start(6'd1);
    checks++;
    if ({done, error, byte_ready} !== 3'b001)
      $display("FAIL illegal_restart: done/err/ready=%b, required 001", {done, error, byte_ready});
    else passed++;
    send_stim(2);
    wait_done("illegal_recover");
    checks++;
    if (error !== 1'b0 || write_errors() !== 0)
      $display("FAIL illegal_recover: err=%b write errors=%0d, required 0 0",
               error, write_errors());
    else passed++;
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    random_stim(6);
    do_start(6'd3);
    send_stim(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({byte_ready, mem_we, cpu_hold, done, error} !== 5'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0)
      $display("FAIL midrst_outputs: flags=%b addr=%h data=%h, required 0 0 0",
               {byte_ready, mem_we, cpu_hold, done, error}, mem_addr, mem_wdata);
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (write_errors() !== 0)
      $display("FAIL midrst_log: %0d writes with %0d errors, required 1 with 0",
               wr_addr.size(), write_errors());
    else passed++;
    clear_log();
    random_stim(4);
    do_start(6'd1);
    send_stim(1);
    wait_done("midrst_restart");
    checks++;
    if (write_errors() !== 0)
      $display("FAIL midrst_restart: %0d writes with %0d errors, required 1 at addr 0 with 0",
               wr_addr.size(), write_errors());
    else passed++;
  endtask

  task automatic test_start_during_load();
    clear_log();
    random_stim(8);
    do_start(6'd2);
    for (int i = 0; i < 8; i++) begin
      send_byte(stim[i]);
      if (i == 2 || i == 3) begin
        // Stray start pulses land in LOAD, then in WRITE.
        start      = 1'b1;
        word_count = 6'd1;
        @(negedge clk);
        start      = 1'b0;
      end
    end
    wait_done("stray_start");
    checks++;
    if (write_errors() !== 0)
      $display("FAIL stray_start_log: %0d writes with %0d errors, required 2 with 0",
               wr_addr.size(), write_errors());
    else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(8, 1);
      clear_log();
      random_stim(4 * n);
      do_start(6'(n));
      send_stim(3);
      wait_done("random");
      checks++;
      if (error !== 1'b0 || write_errors() !== 0)
        $display("FAIL random_%0d: count=%0d writes=%0d errors=%0d err=%b, required 0 errors",
                 it, n, wr_addr.size(), write_errors(), error);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_gaps();
    test_full_depth();
    test_illegal();
    test_reset_mid_load();
    test_start_during_load();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
